trigger_sequencer: RTL

//  GP-engine control stage downstream of the trigger-configuration register file.

---
 rtl/gp_engine_pkg.sv | 9 +
 rtl/trigger_sequencer_if.sv | 29 ++
 rtl/trig_pending_arb.sv | 30 +++
 rtl/trigger_sequencer.sv | 96 +++++++++
 4 files changed

// File: rtl/gp_engine_pkg.sv
// gp_engine_pkg: shared config-field positions, trigger count and sequencer states
package gp_engine_pkg;
  localparam int CFG_EN_BIT   = 31;
  localparam int CFG_RW_BIT   = 30;
  localparam int CFG_ADDR_LSB = 16;
  localparam int NUM_TRIG     = 4;
  localparam int TRIG_IDX_W   = $clog2(NUM_TRIG);
  typedef enum logic [2:0] {IDLE, CFG_REQ, CFG_WAIT, ISSUE, RD_WAIT, DONE} trig_seq_state_e;
endpackage

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: config-read handshake with the register file plus the master bus
interface trigger_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  reg_rd_en;
  logic                  reg_rd_valid;
  logic [DATA_WIDTH-1:0] rd_trig_s1_config;
  logic [DATA_WIDTH-1:0] rd_trig_s2_config;
  logic [DATA_WIDTH-1:0] rd_trig_s3_config;
  logic [DATA_WIDTH-1:0] rd_trig_s4_config;
  logic                  mst_o_valid;
  logic                  mst_o_rd0_wr1;
  logic [ADDR_WIDTH-1:0] mst_o_addr;
  logic [DATA_WIDTH-1:0] mst_o_wr_data;
  logic                  mst_i_ready;
  logic                  mst_i_rd_valid;
  logic [DATA_WIDTH-1:0] mst_i_rd_data;
  modport master (
    output reg_rd_en, mst_o_valid, mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data,
    input  reg_rd_valid, rd_trig_s1_config, rd_trig_s2_config, rd_trig_s3_config,
           rd_trig_s4_config, mst_i_ready, mst_i_rd_valid, mst_i_rd_data
  );
  modport slave (
    input  reg_rd_en, mst_o_valid, mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data,
    output reg_rd_valid, rd_trig_s1_config, rd_trig_s2_config, rd_trig_s3_config,
           rd_trig_s4_config, mst_i_ready, mst_i_rd_valid, mst_i_rd_data
  );
endinterface

// File: rtl/trig_pending_arb.sv
// trig_pending_arb: trigger edge detect, pending bits and fixed-priority grant (trigger 0 highest)
module trig_pending_arb
  import gp_engine_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [NUM_TRIG-1:0]   i_trig,
  input  logic                  i_take,
  output logic [NUM_TRIG-1:0]   o_pending,
  output logic [NUM_TRIG-1:0]   o_grant,
  output logic [TRIG_IDX_W-1:0] o_grant_idx
);
  logic [NUM_TRIG-1:0] trig_q;
  assign o_grant = o_pending & (~o_pending + NUM_TRIG'(1));
  // index of the lowest set pending bit
  always_comb begin
    o_grant_idx = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--)
      if (o_pending[i]) o_grant_idx = TRIG_IDX_W'(i);
  end
  // rises accumulate; a fresh rise on the granted source survives its clear
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      trig_q    <= '0;
      o_pending <= '0;
    end else begin
      trig_q    <= i_trig;
      o_pending <= (o_pending & ~(i_take ? o_grant : '0)) | (i_trig & ~trig_q);
    end
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: fetches the winning trigger's config and runs its bus transaction
module trigger_sequencer
  import gp_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [NUM_TRIG-1:0]   i_trig,
  trigger_sequencer_if.master   bus,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_TRIG-1:0]   o_done,
  output logic [NUM_TRIG-1:0]   o_err,
  output logic                  o_busy
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
  trig_seq_state_e state, state_d;
  logic [TW-1:0] timer;
  logic [NUM_TRIG-1:0] pending, grant, sel_oh;
  logic [TRIG_IDX_W-1:0] grant_idx, sel_idx;
  logic [DATA_WIDTH-1:0] cfg;
  logic take, err_ev, cap_cfg, cap_rd, tmo, cfg_unused;
  trig_pending_arb u_arb (
    .i_clk, .i_rstn, .i_trig, .i_take(take),
    .o_pending(pending), .o_grant(grant), .o_grant_idx(grant_idx)
  );
  assign tmo = timer == T_MAX;
  assign cfg_unused = ^cfg[CFG_RW_BIT-1:ADDR_WIDTH+CFG_ADDR_LSB];
  // config of the trigger in service
  always_comb begin
    cfg = sel_idx == 2'd0 ? bus.rd_trig_s1_config :
          sel_idx == 2'd1 ? bus.rd_trig_s2_config :
          sel_idx == 2'd2 ? bus.rd_trig_s3_config : bus.rd_trig_s4_config;
  end
  // next state and single-cycle events; ready beats a coincident timeout
  always_comb begin
    state_d = state;
    take    = 1'b0;
    err_ev  = 1'b0;
    cap_cfg = 1'b0;
    cap_rd  = 1'b0;
    case (state)
      IDLE:     if (|pending) begin take = 1'b1; state_d = CFG_REQ; end
      CFG_REQ:  state_d = CFG_WAIT;
      CFG_WAIT: if (bus.reg_rd_valid) begin
                  cap_cfg = cfg[CFG_EN_BIT];
                  err_ev  = !cfg[CFG_EN_BIT];
                  state_d = cfg[CFG_EN_BIT] ? ISSUE : IDLE;
                end else if (tmo) begin err_ev = 1'b1; state_d = IDLE; end
      ISSUE:    if (bus.mst_i_ready) state_d = bus.mst_o_rd0_wr1 ? DONE : RD_WAIT;
                else if (tmo) begin err_ev = 1'b1; state_d = IDLE; end
      RD_WAIT:  if (bus.mst_i_rd_valid) begin cap_rd = 1'b1; state_d = DONE; end
                else if (tmo) begin err_ev = 1'b1; state_d = IDLE; end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // state, timer, latched selection and registered outputs
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state             <= IDLE;
      timer             <= '0;
      sel_idx           <= '0;
      sel_oh            <= '0;
      bus.reg_rd_en     <= 1'b0;
      bus.mst_o_valid   <= 1'b0;
      bus.mst_o_rd0_wr1 <= 1'b0;
      bus.mst_o_addr    <= '0;
      bus.mst_o_wr_data <= '0;
      o_rd_data         <= '0;
      o_done            <= '0;
      o_err             <= '0;
      o_busy            <= 1'b0;
    end else begin
      state <= state_d;
      timer <= state_d != state ? '0 : tmo ? timer : timer + TW'(1);
      if (take) begin
        sel_idx <= grant_idx;
        sel_oh  <= grant;
      end
      if (cap_cfg) begin
        bus.mst_o_rd0_wr1 <= cfg[CFG_RW_BIT];
        bus.mst_o_addr    <= cfg[ADDR_WIDTH+CFG_ADDR_LSB-1:CFG_ADDR_LSB];
        bus.mst_o_wr_data <= DATA_WIDTH'(cfg[15:0]);
      end
      if (cap_rd) o_rd_data <= bus.mst_i_rd_data;
      bus.reg_rd_en   <= state_d == CFG_REQ;
      bus.mst_o_valid <= state_d == ISSUE;
      o_busy          <= state_d != IDLE;
      o_done          <= state == DONE ? sel_oh : '0;
      o_err           <= err_ev ? sel_oh : '0;
    end
endmodule
